// File: rtl/pattern_pkg.sv
// Shared pattern buffer geometry and loader state encoding.
// Imported by the loader and by the downstream pattern buffer.
package pattern_pkg;

  localparam int BUFFER_WIDTH = 8;
  localparam int BUFFER_SIZE  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    DONE
  } load_state_t;

endpackage

// File: rtl/pattern_loader.sv
// Serial pattern-buffer loader: shifts bytes MSB-first into a
// daisy-chained buffer while deserializing the old contents back.
module pattern_loader #(
  parameter int BUFFER_WIDTH = pattern_pkg::BUFFER_WIDTH,
  parameter int BUFFER_SIZE  = pattern_pkg::BUFFER_SIZE
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    abort,
  input  logic [BUFFER_WIDTH-1:0] byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    sout_in,
  output logic                    ssel,
  output logic                    sin,
  output logic [BUFFER_WIDTH-1:0] rb_byte,
  output logic                    rb_valid,
  output logic                    busy,
  output logic                    done
);

  import pattern_pkg::*;

  localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;
  localparam int BIT_W = $clog2(BUFFER_WIDTH);
  localparam int MSB   = BUFFER_WIDTH - 1;

  localparam logic [CNT_W-1:0] LAST_BYTE =
    CNT_W'(BUFFER_SIZE - 1);
  localparam logic [BIT_W-1:0] TOP_BIT =
    BIT_W'(BUFFER_WIDTH - 1);

  load_state_t state, state_d;

  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [MSB:0]     shreg, shreg_d;
  logic [MSB:0]     rb_shreg;
  logic [BIT_W-1:0] rb_cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (bit_cnt == '0);

  // Ready in the final bit cycle lets the next byte follow with no gap.
  always_comb begin
    byte_ready = 1'b0;
    if (!rst && !abort) begin
      byte_ready = (state == WAIT_BYTE) ||
                   (last_bit && (byte_cnt < LAST_BYTE));
    end
  end

  assign accept = byte_valid && byte_ready;

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_d    = WAIT_BYTE;
          byte_cnt_d = '0;
        end
      end
      WAIT_BYTE: begin
        if (accept) begin
          shreg_d   = byte_in;
          bit_cnt_d = TOP_BIT;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg << 1;
        if (bit_cnt != '0) begin
          bit_cnt_d = bit_cnt - 1'b1;
        end else begin
          byte_cnt_d = byte_cnt + 1'b1;
          if (accept) begin
            shreg_d   = byte_in;
            bit_cnt_d = TOP_BIT;
          end else if (byte_cnt == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_BYTE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      shreg_d    = '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_d;
      byte_cnt <= byte_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
    end
  end

  // Outputs are registered from next-state so they line up with state.
  always_ff @(posedge sclk) begin
    if (rst) begin
      ssel <= 1'b0;
      sin  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ssel <= (state_d == SHIFT);
      sin  <= (state_d == SHIFT) && shreg_d[MSB];
      busy <= (state_d == WAIT_BYTE) || (state_d == SHIFT);
      done <= (state_d == DONE);
    end
  end

  // Old contents leave the buffer as the new bits enter it.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rb_shreg <= '0;
      rb_cnt   <= '0;
      rb_byte  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (abort) begin
        rb_shreg <= '0;
        rb_cnt   <= '0;
      end else if (ssel) begin
        rb_shreg <= {rb_shreg[MSB-1:0], sout_in};
        rb_cnt   <= rb_cnt + 1'b1;
        if (rb_cnt == TOP_BIT) begin
          rb_byte  <= {rb_shreg[MSB-1:0], sout_in};
          rb_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader with a behavioural downstream buffer
// and a readback scoreboard driven from a load table.
module tb_pattern_loader;

  import pattern_pkg::*;

  localparam int W  = BUFFER_WIDTH;
  localparam int N  = BUFFER_SIZE;
  localparam int NB = W * N;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] step;
    int           gap_at;
    int           gap_len;
    int           kill_at;
    bit           kill_rst;
    int           pulse_at;
    int           exp_ssel;
    int           exp_low;
    int           exp_done;
    int           exp_rb;
  } vec_t;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         load_start = 1'b0;
  logic         abort = 1'b0;
  logic         byte_valid = 1'b0;
  logic [W-1:0] byte_in = '0;
  logic         byte_ready;
  logic         sout_in;
  logic         ssel;
  logic         sin;
  logic [W-1:0] rb_byte;
  logic         rb_valid;
  logic         busy;
  logic         done;
  logic [W+5:0] all_out;

  logic [NB-1:0] pbuf = '0;
  logic [NB-1:0] exp_vec = '0;
  logic [W-1:0]  rb_q[$];
  vec_t          tbl[9];

  int total = 0;
  int bad = 0;

  always #5 sclk = ~sclk;

  // Downstream daisy-chained pattern buffer.
  assign sout_in = pbuf[NB-1];
  always @(posedge sclk) begin
    if (ssel) pbuf <= {pbuf[NB-2:0], sin};
  end

  assign all_out = {ssel, sin, byte_ready, busy,
                    done, rb_valid, rb_byte};

  pattern_loader dut (
    .sclk       (sclk),
    .rst        (rst),
    .load_start (load_start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .sout_in    (sout_in),
    .ssel       (ssel),
    .sin        (sin),
    .rb_byte    (rb_byte),
    .rb_valid   (rb_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic run_load(input int id, input vec_t v);
    int k = 0;
    int gap;
    int cyc = 0;
    int nssel = 0;
    int first = -1;
    int last = -1;
    int ndone = 0;
    int done_cyc = -1;
    int nrb = 0;
    int kill_cyc = -1;
    int idle_bad = 0;
    bit fin = 0;
    logic acc;
    logic [W-1:0] want;
    logic [NB-1:0] stream;
    string tag;

    gap = v.gap_len;
    tag = $sformatf("v%0d", id);
    for (int i = 0; i < N; i++) begin
      stream[NB-1-W*i -: W] = W'(v.base + v.step * i);
    end
    // Old byte N-1-k is expected as the k-th readback byte.
    for (int i = 0; i < N; i++) begin
      rb_q.push_back(exp_vec[NB-1-W*i -: W]);
    end

    @(negedge sclk);
    load_start = 1'b1;
    @(negedge sclk);
    load_start = 1'b0;
    check({tag, " busy_start"}, 64'(busy), 64'd1);

    while (!fin) begin
      cyc++;
      if (ssel) begin
        if (first < 0) first = cyc;
        last = cyc;
        nssel++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (rb_valid) begin
        nrb++;
        if (rb_q.size() > 0) begin
          want = rb_q.pop_front();
          check($sformatf("%s rb%0d", tag, nrb - 1),
                64'(rb_byte), 64'(want));
        end
      end
      if (kill_cyc > 0 && cyc == kill_cyc + 1) begin
        if (v.kill_rst)
          check({tag, " rst_outs"}, 64'(all_out), 64'd0);
        else
          check({tag, " abort_ssel_busy"},
                64'({ssel, busy}), 64'd0);
      end
      if (kill_cyc > 0 && cyc > kill_cyc &&
          (busy || ssel || done || rb_valid)) idle_bad++;

      abort = 1'b0;
      rst = 1'b0;
      load_start = 1'b0;
      if (ssel && kill_cyc < 0 && v.kill_at >= 0 &&
          nssel - 1 == v.kill_at) begin
        kill_cyc = cyc;
        if (v.kill_rst) begin
          rst = 1'b1;
          load_start = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end
      if (ssel && v.pulse_at >= 0 && nssel - 1 == v.pulse_at)
        load_start = 1'b1;
      #1;
      if (k < N && k == v.gap_at + 1 && gap > 0) begin
        byte_valid = 1'b0;
        if (byte_ready) gap--;
      end else begin
        byte_valid = (k < N);
        if (k < N) byte_in = stream[NB-1-W*k -: W];
      end
      acc = byte_valid && byte_ready;
      @(posedge sclk);
      if (acc) k++;
      @(negedge sclk);

      if (done_cyc > 0 && cyc >= done_cyc + 3) fin = 1;
      if (kill_cyc > 0 && cyc >= kill_cyc + 20) fin = 1;
      if (!fin && cyc >= 2000) begin
        total++;
        bad++;
        $display("FAIL %s timeout: got no end after %0d cycles",
                 tag, cyc);
        fin = 1;
      end
    end

    byte_valid = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    load_start = 1'b0;

    check({tag, " ssel_cycles"}, 64'(nssel), 64'(v.exp_ssel));
    check({tag, " ssel_low"},
          64'(last - first + 1 - nssel), 64'(v.exp_low));
    check({tag, " done_count"}, 64'(ndone), 64'(v.exp_done));
    if (v.exp_done > 0)
      check({tag, " done_time"}, 64'(done_cyc), 64'(last + 1));
    check({tag, " rb_count"}, 64'(nrb), 64'(v.exp_rb));
    check({tag, " idle_after_kill"}, 64'(idle_bad), 64'd0);
    check({tag, " busy_end"}, 64'(busy), 64'd0);

    exp_vec = (exp_vec << v.exp_ssel) |
              (stream >> (NB - v.exp_ssel));
    total++;
    if (pbuf !== exp_vec) begin
      bad++;
      $display("FAIL %s buffer: got %h want %h", tag, pbuf, exp_vec);
    end
    rb_q.delete();
  endtask

  initial begin
    // base step gap_at gap_len kill_at kill_rst pulse_at
    // exp_ssel exp_low exp_done exp_rb
    tbl[0] = '{8'h00, 8'h01, -1, 0, -1, 1'b0, -1, 256, 0, 1, 32};
    tbl[1] = '{8'hA5, 8'h00, -1, 0, -1, 1'b0, -1, 256, 0, 1, 32};
    tbl[2] = '{8'h3C, 8'h00, -1, 0, -1, 1'b0, -1, 256, 0, 1, 32};
    tbl[3] = '{8'h00, 8'h01,  3, 5, -1, 1'b0, -1, 256, 5, 1, 32};
    tbl[4] = '{8'h11, 8'h03, -1, 0, 83, 1'b0, -1,  84, 0, 0, 10};
    tbl[5] = '{8'h00, 8'h01, -1, 0, -1, 1'b0, -1, 256, 0, 1, 32};
    tbl[6] = '{8'h22, 8'h05, -1, 0, 50, 1'b1, -1,  51, 0, 0,  6};
    tbl[7] = '{8'h5A, 8'h11, -1, 0, -1, 1'b0, 100, 256, 0, 1, 32};
    tbl[8] = '{8'hF0, 8'hFF, 30, 1, -1, 1'b0, -1, 256, 1, 1, 32};

    repeat (3) @(negedge sclk);
    check("reset_outs", 64'(all_out), 64'd0);
    rst = 1'b0;
    @(negedge sclk);
    check("idle_outs", 64'(all_out), 64'd0);

    load_start = 1'b1;
    abort = 1'b1;
    @(negedge sclk);
    load_start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    @(negedge sclk);
    check("start_abort_idle",
          64'({busy, byte_ready, ssel}), 64'd0);

    for (int i = 0; i < 9; i++) run_load(i, tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 Parameter BUFFER_WIDTH, default 8, SHALL be the bits per pattern byte.
REQ-002 Parameter BUFFER_SIZE, default 32, SHALL be the pattern bytes per full load.
REQ-003 sclk  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 load_start  in  1  SHALL be a one-cycle pulse that begins a full-buffer load; ignored unless idle.
REQ-006 abort  in  1  SHALL terminate any load in progress.
REQ-007 byte_in  in  BUFFER_WIDTH  SHALL be the next pattern byte; pattern byte 31 is sent first.
REQ-008 byte_valid  in  1  SHALL indicate that byte_in is valid.
REQ-009 byte_ready  out  1  SHALL indicate that the loader accepts byte_in in this cycle.
REQ-010 sout_in  in  1  SHALL be the serial output of the downstream pattern buffer, which is its MSB of byte 31.
REQ-011 ssel  out  1  SHALL be the registered shift enable to the pattern buffer.
REQ-012 sin  out  1  SHALL be the registered serial data to the pattern buffer.
REQ-013 rb_byte  out  BUFFER_WIDTH  SHALL be the byte of old buffer contents read back.
REQ-014 rb_valid  out  1  SHALL be a one-cycle strobe qualifying rb_byte.
REQ-015 busy  out  1  SHALL be high from load acceptance until done or abort.
REQ-016 done  out  1  SHALL be a one-cycle pulse when all BUFFER_SIZE bytes are shifted.

Function
REQ-017 The FSM SHALL have four states: IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-018 IDLE->WAIT_BYTE SHALL occur on load_start; the byte counter clears to 0 and busy goes high the next cycle.
REQ-019 byte_ready SHALL be high in WAIT_BYTE, and in the final SHIFT cycle (bit counter=0) when byte count < BUFFER_SIZE-1.
REQ-020 A byte SHALL be accepted on byte_valid & byte_ready: it loads the shift register, the bit counter is set to 7, and the state goes to SHIFT.
REQ-021 In SHIFT, ssel SHALL be 1 and sin SHALL be the shift-register MSB; the byte is sent MSB-first, one bit per cycle, for exactly 8 cycles.
REQ-022 When the last bit of a byte is sent, the byte counter SHALL increment. Next state: SHIFT if a byte was accepted in the same cycle (no gap), else WAIT_BYTE, else DONE if count reaches BUFFER_SIZE.
REQ-023 ssel SHALL be 0 in IDLE, WAIT_BYTE and DONE; the downstream buffer therefore holds during input starvation.
REQ-024 A full load SHALL produce exactly BUFFER_SIZE*8 ssel-high cycles; with byte_valid held high these cycles SHALL be contiguous.
REQ-025 DONE SHALL assert done for one cycle, deassert busy and return to IDLE.
REQ-026 Readback: on every cycle with ssel=1, sout_in SHALL be shifted into the readback register LSB.
REQ-027 Every 8th such sample SHALL produce rb_valid=1 the following cycle; the k-th rb_byte equals the old buffer byte 31-k.
REQ-028 abort SHALL have priority over all events except rst. The FSM goes to IDLE, and ssel=0 from the next cycle.
REQ-029 On abort, the counters SHALL clear, no done pulse is issued, and a partial readback byte is discarded; downstream contents are left partially shifted.
REQ-030 load_start while busy SHALL be ignored. load_start together with abort in IDLE SHALL remain in IDLE.
REQ-031 Byte counter width SHALL be clog2(BUFFER_SIZE)+1; the bit counter SHALL be 3 bits; neither counter wraps within a load.

Reset
REQ-032 rst SHALL force IDLE and clear all counters and registers.
REQ-033 During and after rst, the outputs SHALL be: ssel=0, sin=0, byte_ready=0, busy=0, done=0, rb_valid=0, rb_byte=0.
REQ-034 rst mid-load SHALL behave as abort, and rst SHALL take precedence over abort.

Structure
REQ-035 BUFFER_WIDTH, BUFFER_SIZE and the FSM state encoding SHALL reside in the shared package pattern_pkg, used by both the loader and the pattern buffer.
REQ-036 The block SHALL be a single module without sub-modules; the serializer and readback deserializer are inline shift registers.

Verification
REQ-037 Scenario 1 -- load_start, then bytes 0x00..0x1F offered continuously -> 256 contiguous ssel cycles, done 1 cycle after the last one, and buffer byte 31-k = k.
REQ-038 Scenario 2 -- buffer preloaded with all 0xA5, then a load of 0x3C x32 -> 32 rb_valid strobes each with 0xA5, then the buffer holds 0x3C everywhere.
REQ-039 Scenario 3 -- byte_valid low for 5 cycles after byte 3 -> ssel low for 5 cycles, final buffer contents identical to Scenario 1.
REQ-040 Scenario 4 -- abort on the 4th bit of byte 10 -> ssel=0 next cycle, busy=0, no done, no further rb_valid; a new load_start then runs a complete load.
REQ-041 Scenario 5 -- rst mid-shift, then load_start in the same cycle as rst -> all outputs 0, state IDLE, load_start ignored.
REQ-042 Scenario 6 -- load_start pulsed while busy -> no effect; the byte count completes at exactly 32.
